// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode map, operand-2 source
// selector and the default data-segment / stack-pointer register numbers.
package id_pkg;

    // Opcode map, mirroring opcode.h
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int DS_REG_DEF = 14;
    localparam int SP_REG_DEF = 15;

    // Where ALU operand 2 comes from
    typedef enum logic [2:0] {
        SRC_RF,
        SRC_IMM4S,
        SRC_IMM4Z,
        SRC_IMM8,
        SRC_ONE
    } src_e;

endpackage

// File: rtl/id_fwd_mux.sv
// One operand's bypass selector: EX result beats WB data beats the register
// file. Register 0 is never bypassed, and a disabled port reads as zero.
module id_fwd_mux #(
    parameter int DATA_W = 16,
    parameter int AW     = 4,
    parameter int FWD_EN = 1
) (
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [AW-1:0]     addr_i,
    input  logic              re_i,
    input  logic              ex_we_i,
    input  logic              ex_is_load_i,
    input  logic [AW-1:0]     ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    output logic [DATA_W-1:0] opnd_o
);

    logic live;
    logic ex_hit;
    logic wb_hit;

    // Priority bypass; a load's EX value is not ready yet so it never bypasses
    always_comb begin
        live   = (FWD_EN != 0) && re_i && (addr_i != '0);
        ex_hit = live && ex_we_i && !ex_is_load_i && (ex_waddr_i == addr_i);
        wb_hit = live && wb_we_i && (wb_waddr_i == addr_i);
        if (!re_i)
            opnd_o = '0;
        else if (ex_hit)
            opnd_o = ex_wdata_i;
        else if (wb_hit)
            opnd_o = wb_wdata_i;
        else
            opnd_o = rf_data_i;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction decode: decodes one instruction per cycle, reads the
// register file, bypasses EX/WB results, detects load-use hazards and
// registers the decoded operation into the ID/EX latch.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  NREG   = 16,
    parameter int  DS_REG = DS_REG_DEF,
    parameter int  SP_REG = SP_REG_DEF,
    parameter int  FWD_EN = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              flush,
    output logic [AW-1:0]     p0_addr,
    output logic [AW-1:0]     p1_addr,
    output logic              re0,
    output logic              re1,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    input  logic              ex_we,
    input  logic [AW-1:0]     ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu1,
    output logic [DATA_W-1:0] out_alu2,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_dst,
    output logic              out_we,
    output logic              halted
);

    localparam logic [AW-1:0] DS_A = AW'(DS_REG);
    localparam logic [AW-1:0] SP_A = AW'(SP_REG);

    logic [3:0]        opc;
    logic [AW-1:0]     f2, f1, f0;
    logic [DATA_W-1:0] imm8_z, imm12_s, imm4_s, imm4_z;

    assign opc     = instr[15:12];
    assign f2      = AW'(instr[11:8]);
    assign f1      = AW'(instr[7:4]);
    assign f0      = AW'(instr[3:0]);
    assign imm8_z  = DATA_W'(instr[7:0]);
    assign imm12_s = {{(DATA_W-12){instr[11]}}, instr[11:0]};
    assign imm4_s  = {{(DATA_W-4){instr[3]}}, instr[3:0]};
    assign imm4_z  = DATA_W'(instr[3:0]);

    logic              d_re0, d_re1, d_we, d_hlt;
    logic [AW-1:0]     d_a0, d_a1, d_dst;
    logic [DATA_W-1:0] d_imm;
    src_e              d_src2;

    // Opcode -> read ports, operand-2 source, destination and immediate
    always_comb begin
        d_re0  = 1'b0;
        d_re1  = 1'b0;
        d_a0   = '0;
        d_a1   = '0;
        d_src2 = SRC_RF;
        d_dst  = '0;
        d_we   = 1'b0;
        d_imm  = '0;
        d_hlt  = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
                d_re0 = 1'b1; d_a0 = f1;
                d_re1 = 1'b1; d_a1 = f0;
                d_dst = f2;   d_we = 1'b1;
            end
            OP_INC: begin
                d_re0 = 1'b1; d_a0 = f1; d_src2 = SRC_IMM4S;
                d_dst = f2;   d_we = 1'b1;
            end
            OP_SRA, OP_SRL, OP_SLL: begin
                d_re0 = 1'b1; d_a0 = f1; d_src2 = SRC_IMM4Z;
                d_dst = f2;   d_we = 1'b1;
            end
            OP_SW: begin
                d_re0 = 1'b1; d_a0 = f2;
                d_re1 = 1'b1; d_a1 = DS_A;
                d_imm = imm8_z;
            end
            OP_LW: begin
                d_re1 = 1'b1; d_a1 = DS_A;
                d_dst = f2;   d_we = 1'b1;
                d_imm = imm8_z;
            end
            OP_LHB, OP_LLB: begin
                d_re0 = 1'b1; d_a0 = f2; d_src2 = SRC_IMM8;
                d_dst = f2;   d_we = 1'b1;
                d_imm = imm8_z;
            end
            OP_B: begin
                d_imm = imm12_s;
            end
            OP_CALL, OP_RET: begin
                d_re0 = 1'b1; d_a0 = SP_A; d_src2 = SRC_ONE;
                d_dst = SP_A; d_we = 1'b1;
                d_imm = (opc == OP_CALL) ? imm12_s : '0;
            end
            OP_HLT: d_hlt = 1'b1;
            default: ;
        endcase
    end

    logic rd_en;
    logic halted_q;

    // Reads only happen for a live instruction; addresses park at 0 otherwise
    assign rd_en   = in_valid && !halted_q && !rst;
    assign re0     = d_re0 && rd_en;
    assign re1     = d_re1 && rd_en;
    assign p0_addr = re0 ? d_a0 : '0;
    assign p1_addr = re1 ? d_a1 : '0;

    logic [DATA_W-1:0] fwd0, fwd1;

    id_fwd_mux #(.DATA_W(DATA_W), .AW(AW), .FWD_EN(FWD_EN)) u_fwd0 (
        .rf_data_i(p0), .addr_i(p0_addr), .re_i(re0),
        .ex_we_i(ex_we), .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .opnd_o(fwd0)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .AW(AW), .FWD_EN(FWD_EN)) u_fwd1 (
        .rf_data_i(p1), .addr_i(p1_addr), .re_i(re1),
        .ex_we_i(ex_we), .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .opnd_o(fwd1)
    );

    logic [DATA_W-1:0] alu2;

    // Operand 2: bypassed register or one of the immediate forms
    always_comb begin
        case (d_src2)
            SRC_IMM4S: alu2 = imm4_s;
            SRC_IMM4Z: alu2 = imm4_z;
            SRC_IMM8:  alu2 = imm8_z;
            SRC_ONE:   alu2 = DATA_W'(1);
            default:   alu2 = fwd1;
        endcase
    end

    logic hit_ex0, hit_ex1, hit_wb0, hit_wb1, hazard;
    logic advance, take;
    logic out_valid_q;

    // Without bypassing any in-flight writer of a source register stalls;
    // with it only a load in EX does
    always_comb begin
        hit_ex0 = re0 && (p0_addr != '0) && ex_we && (ex_waddr == p0_addr);
        hit_ex1 = re1 && (p1_addr != '0) && ex_we && (ex_waddr == p1_addr);
        hit_wb0 = re0 && (p0_addr != '0) && wb_we && (wb_waddr == p0_addr);
        hit_wb1 = re1 && (p1_addr != '0) && wb_we && (wb_waddr == p1_addr);
        if (FWD_EN != 0)
            hazard = ex_is_load && (hit_ex0 || hit_ex1);
        else
            hazard = hit_ex0 || hit_ex1 || hit_wb0 || hit_wb1;
    end

    // A flush always drains the current instruction, even into a stalled latch
    assign advance  = out_ready || !out_valid_q;
    assign in_ready = flush ? !halted_q : (advance && !hazard && !halted_q);
    assign take     = in_valid && in_ready && !flush;

    logic [DATA_W-1:0] alu1_q, alu2_q, imm_q, alu1_d, alu2_d, imm_d;
    logic [3:0]        op_q, op_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic              we_q, we_d, valid_d, halted_d;

    // ID/EX latch next state: load, bubble/kill, or hold under backpressure
    always_comb begin
        valid_d  = out_valid_q;
        alu1_d   = alu1_q;
        alu2_d   = alu2_q;
        imm_d    = imm_q;
        op_d     = op_q;
        dst_d    = dst_q;
        we_d     = we_q;
        halted_d = halted_q || (take && d_hlt);
        if (take) begin
            valid_d = 1'b1;
            alu1_d  = fwd0;
            alu2_d  = alu2;
            imm_d   = d_imm;
            op_d    = opc;
            dst_d   = d_dst;
            we_d    = d_we;
        end else if (flush || advance) begin
            valid_d = 1'b0;
            alu1_d  = '0;
            alu2_d  = '0;
            imm_d   = '0;
            op_d    = '0;
            dst_d   = '0;
            we_d    = 1'b0;
        end
    end

    // ID/EX latch and sticky halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu1_q      <= '0;
            alu2_q      <= '0;
            imm_q       <= '0;
            op_q        <= '0;
            dst_q       <= '0;
            we_q        <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= valid_d;
            alu1_q      <= alu1_d;
            alu2_q      <= alu2_d;
            imm_q       <= imm_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            we_q        <= we_d;
            halted_q    <= halted_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_alu1   = alu1_q;
    assign out_alu2   = alu2_q;
    assign out_imm    = imm_q;
    assign out_opcode = op_q;
    assign out_dst    = dst_q;
    assign out_we     = we_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios then random traffic, checked
// against an instruction-level model of decode, bypass, hazard and latch.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [15:0] instr;
    logic [3:0]  p0_addr, p1_addr;
    logic        re0, re1;
    logic [15:0] p0, p1;
    logic        ex_we, ex_is_load, wb_we;
    logic [3:0]  ex_waddr, wb_waddr;
    logic [15:0] ex_wdata, wb_wdata;
    logic        out_valid, out_ready, out_we, halted;
    logic [15:0] out_alu1, out_alu2, out_imm;
    logic [3:0]  out_opcode, out_dst;

    logic [15:0] regs [16];
    assign p0 = regs[p0_addr];
    assign p1 = regs[p1_addr];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .p0(p0), .p1(p1), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_is_load(ex_is_load), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu1(out_alu1),
        .out_alu2(out_alu2), .out_opcode(out_opcode), .out_imm(out_imm),
        .out_dst(out_dst), .out_we(out_we), .halted(halted)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] a1, a2, imm;
        logic [3:0]  op, dst;
        logic        we, hlt;
        logic        r0e, r1e;
        logic [3:0]  r0, r1;
    } dec_t;

    dec_t m_q;
    logic m_valid, m_halted;

    // Value a source register holds from ID's point of view right now
    function automatic logic [15:0] fw(input logic [3:0] a);
        if (a != 0 && ex_we && !ex_is_load && ex_waddr == a) return ex_wdata;
        if (a != 0 && wb_we && wb_waddr == a) return wb_wdata;
        return regs[a];
    endfunction

    // Instruction meaning: which registers it reads, then the operand values
    function automatic dec_t mdec(input logic [15:0] ins);
        dec_t d;
        logic [3:0] a, b, c;
        d = '0;
        a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
        d.op = ins[15:12];
        case (ins[15:12])
            4'h0, 4'h1, 4'h2, 4'h3: begin
                d.r0e = 1; d.r0 = b; d.r1e = 1; d.r1 = c; d.dst = a; d.we = 1;
            end
            4'h4: begin
                d.r0e = 1; d.r0 = b; d.dst = a; d.we = 1;
                d.a2 = 16'(c) - (c[3] ? 16'd16 : 16'd0);
            end
            4'h5, 4'h6, 4'h7: begin
                d.r0e = 1; d.r0 = b; d.dst = a; d.we = 1; d.a2 = 16'(c);
            end
            4'h8: begin
                d.r0e = 1; d.r0 = a; d.r1e = 1; d.r1 = 14; d.imm = 16'(ins[7:0]);
            end
            4'h9: begin
                d.r1e = 1; d.r1 = 14; d.dst = a; d.we = 1; d.imm = 16'(ins[7:0]);
            end
            4'hA, 4'hB: begin
                d.r0e = 1; d.r0 = a; d.dst = a; d.we = 1;
                d.a2 = 16'(ins[7:0]); d.imm = 16'(ins[7:0]);
            end
            4'hC: d.imm = 16'(ins[11:0]) + (ins[11] ? 16'hF000 : 16'h0000);
            4'hD: begin
                d.r0e = 1; d.r0 = 15; d.dst = 15; d.we = 1; d.a2 = 16'd1;
                d.imm = 16'(ins[11:0]) + (ins[11] ? 16'hF000 : 16'h0000);
            end
            4'hE: begin
                d.r0e = 1; d.r0 = 15; d.dst = 15; d.we = 1; d.a2 = 16'd1;
            end
            default: d.hlt = 1;
        endcase
        if (d.r0e) d.a1 = fw(d.r0);
        if (d.r1e) d.a2 = fw(d.r1);
        return d;
    endfunction

    task automatic idle();
        in_valid = 0; instr = 16'h0; flush = 0; out_ready = 1;
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    endtask

    // One clock: check handshake against the model, advance, check the latch
    task automatic step();
        dec_t d;
        logic haz, adv, rdy, n_valid, n_h;
        dec_t n_q;
        #1;
        d   = mdec(instr);
        haz = in_valid && ex_is_load && ex_we && ex_waddr != 0 &&
              ((d.r0e && d.r0 == ex_waddr) || (d.r1e && d.r1 == ex_waddr));
        adv = out_ready || !m_valid;
        rdy = flush ? !m_halted : (adv && !haz && !m_halted);
        chk("in_ready", in_ready, rdy);
        n_valid = m_valid; n_q = m_q; n_h = m_halted;
        if (flush) n_valid = 0;
        else if (adv) begin
            if (in_valid && rdy) begin
                n_valid = 1; n_q = d;
                if (d.hlt) n_h = 1;
            end else n_valid = 0;
        end
        @(posedge clk); #1;
        m_valid = n_valid; m_q = n_q; m_halted = n_h;
        chk("out_valid", out_valid, m_valid);
        chk("halted", halted, m_halted);
        if (m_valid) begin
            chk("alu1", out_alu1, m_q.a1);
            chk("alu2", out_alu2, m_q.a2);
            chk("opcode", out_opcode, m_q.op);
            chk("imm", out_imm, m_q.imm);
            chk("dst", out_dst, m_q.dst);
            chk("we", out_we, m_q.we);
        end
    endtask

    task automatic do_rst();
        rst = 1; #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alu1", out_alu1, 0);
        chk("rst_re0", re0, 0);
        chk("rst_re1", re1, 0);
        m_valid = 0; m_halted = 0; m_q = '0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    function automatic logic [3:0] rreg();
        int k;
        k = $urandom_range(0, 5);
        return (k == 4) ? 4'd14 : (k == 5) ? 4'd15 : 4'(k);
    endfunction

    initial begin
        rst = 0;
        idle();
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        regs[2] = 16'hABCD; regs[3] = 16'hDEAD; regs[15] = 16'h1234;
        in_valid = 1; instr = 16'h0123;
        #3;
        do_rst();

        // ADD r1,r2,r3 from the register file
        idle(); in_valid = 1; instr = 16'h0123; step();
        chk("add_a1", out_alu1, 16'hABCD);
        chk("add_a2", out_alu2, 16'hDEAD);
        chk("add_dst", out_dst, 1);

        // INC -1, SLL 8, CALL
        regs[2] = 16'hBABE;
        instr = 16'h412F; step();
        chk("inc_a2", out_alu2, 16'hFFFF);
        instr = 16'h7128; step();
        chk("sll_a2", out_alu2, 16'h0008);
        instr = 16'hD000; step();
        chk("call_a1", out_alu1, 16'h1234);
        chk("call_a2", out_alu2, 16'h0001);

        // EX beats WB on the same register
        instr = 16'h3123;
        ex_we = 1; ex_waddr = 2; ex_wdata = 16'h1111;
        wb_we = 1; wb_waddr = 2; wb_wdata = 16'h2222;
        step();
        chk("fwd_ex", out_alu1, 16'h1111);

        // Load-use: one bubble, then WB supplies the loaded value
        idle(); in_valid = 1; instr = 16'h0123;
        ex_we = 1; ex_is_load = 1; ex_waddr = 2; ex_wdata = 16'h9999;
        step();
        chk("lu_bubble", out_valid, 0);
        ex_we = 0; ex_is_load = 0;
        wb_we = 1; wb_waddr = 2; wb_wdata = 16'h5555;
        step();
        chk("lu_fwd", out_alu1, 16'h5555);

        // Backpressure holds the latch, then flush kills it
        idle(); in_valid = 1; instr = 16'h0456; out_ready = 0;
        repeat (3) step();
        chk("bp_hold", out_alu1, 16'h5555);
        chk("bp_rdy", in_ready, 0);
        flush = 1; step();
        chk("flush_v", out_valid, 0);

        // HLT then ADD is refused
        idle(); in_valid = 1; instr = 16'hF000; step();
        chk("hlt_set", halted, 1);
        instr = 16'h0123; step();
        chk("hlt_rdy", in_ready, 0);
        do_rst();

        // Random traffic
        for (int i = 0; i < 30; i++) regs[i % 16] = 16'($urandom);
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] op;
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_rst();
                continue;
            end
            in_valid = $urandom_range(0, 9) < 8;
            op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            instr = {op, rreg(), rreg(), rreg()};
            if ($urandom_range(0, 1) == 1) instr[11:0] = 12'($urandom);
            flush      = $urandom_range(0, 9) == 0;
            out_ready  = $urandom_range(0, 9) < 7;
            ex_we      = $urandom_range(0, 1) == 1;
            ex_waddr   = rreg();
            ex_wdata   = 16'($urandom);
            ex_is_load = $urandom_range(0, 2) == 0;
            wb_we      = $urandom_range(0, 1) == 1;
            wb_waddr   = rreg();
            wb_wdata   = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
